reset_sequencer: RTL

- Sequences reset release for NUM_DOMAINS clock-synchronous reset domains that share one clock.
- Holds every domain in reset until the PLL lock is stable, then releases the domains one at a time in index order, with a fixed gap between releases.
- Also services a software reset request: it re-asserts every domain reset and then runs the release sequence again.
- Sits at the top level between the board reset/PLL and all domain reset inputs.

---
 rtl/reset_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Power-up / software reset sequencer: holds all domains until PLL lock is stable, then releases them in order.
// Optional lock-loss monitor enabled by defining RESET_SEQ_LOCK_MON_EN.
//
// state    | meaning
// HOLD     | all domains in reset, waiting for lock_s to stay high long enough
// RELEASE  | releasing domains one at a time, DELAY_CYCLES apart
// RUN      | all domains out of reset, _oReady high
// SW_RESET | all domains held in reset for SW_RESET_CYCLES after a software request
module reset_sequencer #(
  parameter int NUM_DOMAINS        = 3,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int DELAY_CYCLES       = 8,
  parameter int SW_RESET_CYCLES    = 4
) (
  input  logic                   _iClk,
  input  logic                   _iReset,
  input  logic                   _iPllLocked,
  input  logic                   _iSwResetReq,
  output logic [NUM_DOMAINS-1:0] _oReset,
  output logic                   _oReady,
  output logic                   _oLockLost
);

  localparam int MAX_AB     = (LOCK_STABLE_CYCLES > DELAY_CYCLES) ? LOCK_STABLE_CYCLES : DELAY_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > SW_RESET_CYCLES) ? MAX_AB : SW_RESET_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int IW         = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] SW_LAST    = CW'(SW_RESET_CYCLES - 1);
  localparam logic [IW-1:0] LAST_DOMAIN = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOMAIN0 = NUM_DOMAINS'(1);

  localparam logic [1:0] HOLD     = 2'd0;
  localparam logic [1:0] RELEASE  = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;
  localparam logic [1:0] SW_RESET = 2'd3;

  logic [1:0]    rstSync;
  logic          rstS;
  logic [1:0]    lockSync;
  logic          lockS;
  logic          lockDrop;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  // Asserts immediately with _iReset, releases two clock edges after it falls.
  always_ff @(posedge _iClk or posedge _iReset) begin
    if (_iReset) rstSync <= 2'b11;
    else         rstSync <= {rstSync[0], 1'b0};
  end
  assign rstS = rstSync[1];

  always_ff @(posedge _iClk or posedge rstS) begin
    if (rstS) lockSync <= 2'b00;
    else      lockSync <= {lockSync[0], _iPllLocked};
  end
  assign lockS = lockSync[1];

`ifdef RESET_SEQ_LOCK_MON_EN
  assign lockDrop = ~lockS && (state != HOLD);

  always_ff @(posedge _iClk or posedge rstS) begin
    if (rstS)          _oLockLost <= 1'b0;
    else if (lockDrop) _oLockLost <= 1'b1;
  end
`else
  assign lockDrop   = 1'b0;
  assign _oLockLost = 1'b0;
`endif

  always_ff @(posedge _iClk or posedge rstS) begin
    if (rstS) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      _oReset <= '1;
      _oReady <= 1'b0;
    end else if (lockDrop) begin
      // Lock loss outranks a coincident software request.
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      _oReset <= '1;
      _oReady <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          _oReset <= '1;
          _oReady <= 1'b0;
          if (!lockS) begin
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == DELAY_LAST) begin
            cnt     <= '0;
            idx     <= idx + IW'(1);
            _oReset <= _oReset & ~(DOMAIN0 << idx);
            if (idx == LAST_DOMAIN) begin
              state   <= RUN;
              _oReady <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (_iSwResetReq) begin
            state   <= SW_RESET;
            cnt     <= '0;
            _oReset <= '1;
            _oReady <= 1'b0;
          end
        end
        SW_RESET: begin
          if (cnt == SW_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
